// File: rtl/tick_scheduler_if.sv
// Bus bundle of tick_scheduler: run enables, divisor write handshake and
// the per-channel tick / square outputs.
interface tick_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             ts_en_a;
    logic             ts_en_b;
    logic             ts_cfg_valid;
    logic             ts_cfg_sel;
    logic [CNT_W-1:0] ts_cfg_div;
    logic             ts_cfg_ready;
    logic             ts_tick_a;
    logic             ts_tick_b;
    logic             ts_clk_out_a;
    logic             ts_clk_out_b;

    modport master (
        output ts_en_a, ts_en_b, ts_cfg_valid, ts_cfg_sel, ts_cfg_div,
        input  ts_cfg_ready, ts_tick_a, ts_tick_b, ts_clk_out_a, ts_clk_out_b
    );

    modport slave (
        input  ts_en_a, ts_en_b, ts_cfg_valid, ts_cfg_sel, ts_cfg_div,
        output ts_cfg_ready, ts_tick_a, ts_tick_b, ts_clk_out_a, ts_clk_out_b
    );
endinterface

// File: rtl/tick_scheduler.sv
// Two-channel programmable tick scheduler with divisor updates deferred to period wraps.
// Define TS_CLK_OUT_EN to build the 50 % square outputs; otherwise they are tied low.
module tick_scheduler #(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] DEF_DIV_A = CNT_W'(25000),
    parameter logic [CNT_W-1:0] DEF_DIV_B = CNT_W'(125)
) (
    input  logic            ts_clk_in,
    input  logic            ts_rst_n,
    tick_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_e;

    // A zero divisor would never wrap, so it is stored as 1.
    function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
        sat_div = (d == CNT_W'(0)) ? CNT_W'(1) : d;
    endfunction

    ch_state_e        state_r    [2];
    ch_state_e        state_nx_s [2];
    logic [CNT_W-1:0] cnt_r      [2];
    logic [CNT_W-1:0] cnt_nx_s   [2];
    logic [CNT_W-1:0] div_r      [2];
    logic [CNT_W-1:0] div_nx_s   [2];
    logic [CNT_W-1:0] pend_r     [2];
    logic [CNT_W-1:0] pend_nx_s  [2];
    logic             tick_r     [2];
    logic             tick_nx_s  [2];
    logic             wrap_s     [2];
    logic             xfer_s     [2];
    logic             en_s       [2];
    logic [1:0]       sel_hot_s;
    logic [CNT_W-1:0] cfg_div_s;
    logic             ready_s;

    assign en_s[0]   = bus.ts_en_a;
    assign en_s[1]   = bus.ts_en_b;
    assign sel_hot_s = {bus.ts_cfg_sel, ~bus.ts_cfg_sel};
    assign cfg_div_s = sat_div(bus.ts_cfg_div);

    // Handshake: a channel holding a queued divisor refuses further writes.
    always_comb begin
        ready_s = 1'b1;
        if (bus.ts_cfg_sel) begin
            ready_s = (state_r[1] != ST_PEND);
        end else begin
            ready_s = (state_r[0] != ST_PEND);
        end
        for (int c = 0; c < 2; c++) begin
            xfer_s[c] = bus.ts_cfg_valid && ready_s && sel_hot_s[c];
        end
    end

    // Per-channel next state, counter, divisor and tick.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_nx_s[c] = state_r[c];
            cnt_nx_s[c]   = cnt_r[c];
            div_nx_s[c]   = div_r[c];
            pend_nx_s[c]  = pend_r[c];
            tick_nx_s[c]  = 1'b0;
            wrap_s[c]     = (cnt_r[c] == (div_r[c] - CNT_W'(1)));
            case (state_r[c])
                ST_IDLE: begin
                    cnt_nx_s[c] = CNT_W'(0);
                    if (xfer_s[c]) begin
                        div_nx_s[c] = cfg_div_s;
                    end else begin
                        div_nx_s[c] = div_r[c];
                    end
                    if (en_s[c]) begin
                        state_nx_s[c] = ST_RUN;
                    end else begin
                        state_nx_s[c] = ST_IDLE;
                    end
                end
                ST_RUN, ST_PEND: begin
                    if (!en_s[c]) begin
                        // Stopping: a queued or just-written divisor takes effect now.
                        state_nx_s[c] = ST_IDLE;
                        cnt_nx_s[c]   = CNT_W'(0);
                        if (state_r[c] == ST_PEND) begin
                            div_nx_s[c] = pend_r[c];
                        end else if (xfer_s[c]) begin
                            div_nx_s[c] = cfg_div_s;
                        end else begin
                            div_nx_s[c] = div_r[c];
                        end
                    end else begin
                        if (wrap_s[c]) begin
                            cnt_nx_s[c]  = CNT_W'(0);
                            tick_nx_s[c] = 1'b1;
                            if (state_r[c] == ST_PEND) begin
                                div_nx_s[c]   = pend_r[c];
                                state_nx_s[c] = ST_RUN;
                            end else begin
                                state_nx_s[c] = state_r[c];
                            end
                        end else begin
                            cnt_nx_s[c] = cnt_r[c] + CNT_W'(1);
                        end
                        // A write landing on a wrap edge still waits for the next wrap.
                        if (xfer_s[c]) begin
                            pend_nx_s[c]  = cfg_div_s;
                            state_nx_s[c] = ST_PEND;
                        end else begin
                            pend_nx_s[c]  = pend_r[c];
                        end
                    end
                end
                default: begin
                    state_nx_s[c] = ST_IDLE;
                    cnt_nx_s[c]   = CNT_W'(0);
                end
            endcase
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge ts_clk_in) begin
        for (int c = 0; c < 2; c++) begin
            if (!ts_rst_n) begin
                state_r[c] <= ST_IDLE;
                cnt_r[c]   <= CNT_W'(0);
                div_r[c]   <= (c == 0) ? sat_div(DEF_DIV_A) : sat_div(DEF_DIV_B);
                pend_r[c]  <= CNT_W'(0);
                tick_r[c]  <= 1'b0;
            end else begin
                state_r[c] <= state_nx_s[c];
                cnt_r[c]   <= cnt_nx_s[c];
                div_r[c]   <= div_nx_s[c];
                pend_r[c]  <= pend_nx_s[c];
                tick_r[c]  <= tick_nx_s[c];
            end
        end
    end

    assign bus.ts_cfg_ready = ready_s;
    assign bus.ts_tick_a    = tick_r[0];
    assign bus.ts_tick_b    = tick_r[1];

`ifdef TS_CLK_OUT_EN
    logic tgl_r [2];

    // Square outputs flip on every wrap and drop whenever a channel is not running.
    always_ff @(posedge ts_clk_in) begin
        for (int c = 0; c < 2; c++) begin
            if (!ts_rst_n) begin
                tgl_r[c] <= 1'b0;
            end else if ((state_r[c] == ST_IDLE) || !en_s[c]) begin
                tgl_r[c] <= 1'b0;
            end else if (tick_nx_s[c]) begin
                tgl_r[c] <= ~tgl_r[c];
            end else begin
                tgl_r[c] <= tgl_r[c];
            end
        end
    end

    assign bus.ts_clk_out_a = tgl_r[0];
    assign bus.ts_clk_out_b = tgl_r[1];
`else
    assign bus.ts_clk_out_a = 1'b0;
    assign bus.ts_clk_out_b = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed plus randomized bench for tick_scheduler, checked cycle by cycle
// against a period-counting reference model of both channels.
module tb_tick_scheduler;

    localparam int DEF_A = 4;
    localparam int DEF_B = 5;
`ifdef TS_CLK_OUT_EN
    localparam bit CLK_OUT_ON = 1'b1;
`else
    localparam bit CLK_OUT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tick_scheduler_if #(.CNT_W(32)) bus ();

    tick_scheduler #(
        .CNT_W    (32),
        .DEF_DIV_A(32'(DEF_A)),
        .DEF_DIV_B(32'(DEF_B))
    ) dut (
        .ts_clk_in(clk),
        .ts_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles elapsed in the current period, divisor, queued divisor.
    bit          m_run      [2];
    int unsigned m_elapsed  [2];
    int unsigned m_div      [2];
    bit          m_has_pend [2];
    int unsigned m_pend     [2];
    bit          m_tick     [2];
    bit          m_clk      [2];

    function automatic void model_edge();
        bit          en   [2];
        bit          xfer;
        int unsigned nd;
        en[0] = bus.ts_en_a;
        en[1] = bus.ts_en_b;
        nd = (bus.ts_cfg_div == 32'd0) ? 1 : int'(bus.ts_cfg_div);
        for (int c = 0; c < 2; c++) begin
            xfer = bus.ts_cfg_valid && (int'(bus.ts_cfg_sel) == c) && !m_has_pend[c];
            if (!rst_n) begin
                m_run[c] = 1'b0; m_elapsed[c] = 0; m_has_pend[c] = 1'b0;
                m_div[c] = (c == 0) ? DEF_A : DEF_B;
                m_tick[c] = 1'b0; m_clk[c] = 1'b0;
            end else if (!m_run[c]) begin
                m_tick[c] = 1'b0; m_clk[c] = 1'b0;
                if (xfer) m_div[c] = nd;
                if (en[c]) begin m_run[c] = 1'b1; m_elapsed[c] = 0; end
            end else if (!en[c]) begin
                m_run[c] = 1'b0; m_tick[c] = 1'b0; m_clk[c] = 1'b0; m_elapsed[c] = 0;
                if (m_has_pend[c]) begin m_div[c] = m_pend[c]; m_has_pend[c] = 1'b0; end
                else if (xfer) m_div[c] = nd;
            end else begin
                m_elapsed[c]++;
                if (m_elapsed[c] == m_div[c]) begin
                    m_tick[c] = 1'b1; m_clk[c] = ~m_clk[c]; m_elapsed[c] = 0;
                    if (m_has_pend[c]) begin m_div[c] = m_pend[c]; m_has_pend[c] = 1'b0; end
                end else begin
                    m_tick[c] = 1'b0;
                end
                if (xfer) begin m_has_pend[c] = 1'b1; m_pend[c] = nd; end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, outputs just after it.
    task automatic cyc();
        #1;
        check("ready", {31'd0, bus.ts_cfg_ready}, {31'd0, !m_has_pend[bus.ts_cfg_sel]});
        @(posedge clk);
        model_edge();
        #1;
        check("tick_a", {31'd0, bus.ts_tick_a}, {31'd0, m_tick[0]});
        check("tick_b", {31'd0, bus.ts_tick_b}, {31'd0, m_tick[1]});
        check("clk_out_a", {31'd0, bus.ts_clk_out_a}, {31'd0, CLK_OUT_ON ? m_clk[0] : 1'b0});
        check("clk_out_b", {31'd0, bus.ts_clk_out_b}, {31'd0, CLK_OUT_ON ? m_clk[1] : 1'b0});
    endtask

    task automatic write_div(input bit sel, input int unsigned d);
        bus.ts_cfg_valid = 1'b1;
        bus.ts_cfg_sel   = sel;
        bus.ts_cfg_div   = d;
        cyc();
        bus.ts_cfg_valid = 1'b0;
    endtask

    initial begin
        bit found;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ts_en_a = 1'b0; bus.ts_en_b = 1'b0;
        bus.ts_cfg_valid = 1'b0; bus.ts_cfg_sel = 1'b0; bus.ts_cfg_div = 32'd0;

        // Reset state.
        @(posedge clk);
        model_edge();
        repeat (2) cyc();
        rst_n = 1'b1;

        // Channel A on its default divisor.
        bus.ts_en_a = 1'b1;
        repeat (20) cyc();

        // Channel B at 5, rewritten to 3 mid-period.
        bus.ts_en_b = 1'b1;
        repeat (3) cyc();
        write_div(1'b1, 3);
        repeat (16) cyc();

        // Write to A on the very edge it wraps: 4 then 6.
        for (int i = 0; i < 20 && !(m_run[0] && m_elapsed[0] == m_div[0] - 1); i++) cyc();
        found = m_run[0] && (m_elapsed[0] == m_div[0] - 1);
        check("wrap_align", {31'd0, found}, 32'd1);
        write_div(1'b0, 6);
        repeat (20) cyc();

        // Divisor 0 written to idle A behaves as 1.
        bus.ts_en_a = 1'b0;
        cyc();
        write_div(1'b0, 0);
        bus.ts_en_a = 1'b1;
        repeat (10) cyc();

        // Stop A with 7 still queued, then restart.
        write_div(1'b0, 9);
        repeat (3) cyc();
        write_div(1'b0, 7);
        repeat (2) cyc();
        bus.ts_en_a = 1'b0;
        repeat (3) cyc();
        bus.ts_en_a = 1'b1;
        repeat (20) cyc();

        // Randomized enables and divisor writes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bus.ts_en_a = ~bus.ts_en_a;
            if ($urandom_range(0, 19) == 0) bus.ts_en_b = ~bus.ts_en_b;
            bus.ts_cfg_valid = ($urandom_range(0, 3) == 0);
            bus.ts_cfg_sel   = 1'($urandom_range(0, 1));
            bus.ts_cfg_div   = $urandom_range(0, 8);
            cyc();
        end
        bus.ts_cfg_valid = 1'b0;

        // One-cycle reset while both channels run; defaults must return.
        bus.ts_en_a = 1'b1; bus.ts_en_b = 1'b1;
        repeat (6) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (25) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
